// File: rtl/pixel_req_gen.sv
// Per-pixel event-to-request generator for one level-0 arbiter group.
// Each pixel latches an event polarity, holds it until granted, then sits out a refractory hold.
package lib_arbiter_pkg;
   localparam int POLARITY = 2;
endpackage

module pixel_req_gen
   import lib_arbiter_pkg::*;
#(
   parameter int Lvl0_ROWS     = 2,
   parameter int Lvl0_COLS     = 2,
   parameter int REFRAC_CYCLES = 4
) (
   input  logic                                            clk_i,
   input  logic                                            reset_i,
   input  logic                                            enable_i,
   input  logic [Lvl0_ROWS-1:0][Lvl0_COLS-1:0][POLARITY-1:0] event_i,
   input  logic [Lvl0_ROWS-1:0][Lvl0_COLS-1:0]               gnt_i,
   output logic [Lvl0_ROWS-1:0][Lvl0_COLS-1:0][POLARITY-1:0] req_o,
   output logic                                            busy_o,
   output logic                                            drop_o,
   output logic [15:0]                                     drop_cnt_o
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      PEND   = 2'd1,
      REFRAC = 2'd2
   } pixState_t;

   localparam logic [7:0] REFRAC_LOAD = 8'(REFRAC_CYCLES);

   pixState_t                                        r_state     [Lvl0_ROWS][Lvl0_COLS];
   pixState_t                                        w_nextState [Lvl0_ROWS][Lvl0_COLS];
   logic [7:0]                                       r_cnt       [Lvl0_ROWS][Lvl0_COLS];
   logic [7:0]                                       w_nextCnt   [Lvl0_ROWS][Lvl0_COLS];
   logic [Lvl0_ROWS-1:0][Lvl0_COLS-1:0][POLARITY-1:0] r_req;
   logic [Lvl0_ROWS-1:0][Lvl0_COLS-1:0][POLARITY-1:0] w_nextReq;
   logic                                             w_anyDrop;
   logic                                             w_anyBusy;
   logic                                             r_busy;
   logic                                             r_drop;
   logic [15:0]                                      r_dropCnt;

   // Any event hitting a pixel that is not free to capture is a drop, as is a two-polarity collision.
   always_comb begin
      w_anyDrop = 1'b0;
      w_anyBusy = 1'b0;
      w_nextReq = r_req;
      for (int r = 0; r < Lvl0_ROWS; r++) begin
         for (int c = 0; c < Lvl0_COLS; c++) begin
            w_nextState[r][c] = r_state[r][c];
            w_nextCnt[r][c]   = r_cnt[r][c];
            case (r_state[r][c])
               IDLE: begin
                  if (enable_i && (|event_i[r][c])) begin
                     w_nextState[r][c] = PEND;
                     w_nextReq[r][c]   = event_i[r][c][1] ? 2'b10 : 2'b01;
                     if (&event_i[r][c]) begin
                        w_anyDrop = 1'b1;
                     end
                  end
               end
               PEND: begin
                  if (|event_i[r][c]) begin
                     w_anyDrop = 1'b1;
                  end
                  if (gnt_i[r][c]) begin
                     w_nextReq[r][c] = '0;
                     if (REFRAC_CYCLES > 0) begin
                        w_nextState[r][c] = REFRAC;
                        w_nextCnt[r][c]   = REFRAC_LOAD;
                     end else begin
                        w_nextState[r][c] = IDLE;
                     end
                  end
               end
               REFRAC: begin
                  if (|event_i[r][c]) begin
                     w_anyDrop = 1'b1;
                  end
                  w_nextCnt[r][c] = r_cnt[r][c] - 8'd1;
                  if (r_cnt[r][c] == 8'd1) begin
                     w_nextState[r][c] = IDLE;
                  end
               end
               default: begin
                  w_nextState[r][c] = IDLE;
                  w_nextCnt[r][c]   = '0;
                  w_nextReq[r][c]   = '0;
               end
            endcase
            if (w_nextState[r][c] != IDLE) begin
               w_anyBusy = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         for (int r = 0; r < Lvl0_ROWS; r++) begin
            for (int c = 0; c < Lvl0_COLS; c++) begin
               r_state[r][c] <= IDLE;
               r_cnt[r][c]   <= '0;
            end
         end
         r_req     <= '0;
         r_busy    <= 1'b0;
         r_drop    <= 1'b0;
         r_dropCnt <= '0;
      end else begin
         for (int r = 0; r < Lvl0_ROWS; r++) begin
            for (int c = 0; c < Lvl0_COLS; c++) begin
               r_state[r][c] <= w_nextState[r][c];
               r_cnt[r][c]   <= w_nextCnt[r][c];
            end
         end
         r_req  <= w_nextReq;
         r_busy <= w_anyBusy;
         r_drop <= w_anyDrop;
         if (w_anyDrop && (r_dropCnt != 16'hFFFF)) begin
            r_dropCnt <= r_dropCnt + 16'd1;
         end
      end
   end

   assign req_o      = r_req;
   assign busy_o     = r_busy;
   assign drop_o     = r_drop;
   assign drop_cnt_o = r_dropCnt;

endmodule

// File: tb/tb_pixel_req_gen.sv
// Self-checking bench for pixel_req_gen: directed scenarios plus random traffic,
// compared every cycle against a cycle-index based reference model.
module tb_pixel_req_gen;

   localparam int ROWS   = 2;
   localparam int COLS   = 2;
   localparam int REFRAC = 4;

   logic                             clk_i;
   logic                             reset_i;
   logic                             enable_i;
   logic [ROWS-1:0][COLS-1:0][1:0]   eventIn;
   logic [ROWS-1:0][COLS-1:0]        gntIn;
   logic [ROWS-1:0][COLS-1:0][1:0]   reqOut;
   logic                             busyOut;
   logic                             dropOut;
   logic [15:0]                      dropCntOut;

   int testCnt = 0;
   int failCnt = 0;

   // Reference model: a pixel is pending with a polarity, or refractory until a given edge index.
   bit         mPend   [ROWS][COLS];
   logic [1:0] mPol    [ROWS][COLS];
   int         mFreeAt [ROWS][COLS];
   int         edgeIdx = 0;
   logic       mDrop;
   int         mCnt;

   pixel_req_gen #(
      .Lvl0_ROWS(ROWS),
      .Lvl0_COLS(COLS),
      .REFRAC_CYCLES(REFRAC)
   ) dut (
      .clk_i(clk_i),
      .reset_i(reset_i),
      .enable_i(enable_i),
      .event_i(eventIn),
      .gnt_i(gntIn),
      .req_o(reqOut),
      .busy_o(busyOut),
      .drop_o(dropOut),
      .drop_cnt_o(dropCntOut)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      testCnt++;
      assert (obs === exp) else begin
         failCnt++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic modelReset();
      for (int r = 0; r < ROWS; r++) begin
         for (int c = 0; c < COLS; c++) begin
            mPend[r][c]   = 1'b0;
            mPol[r][c]    = 2'b00;
            mFreeAt[r][c] = -1;
         end
      end
      mDrop = 1'b0;
      mCnt  = 0;
   endtask

   // One clock edge of the spec rules, using the inputs currently driven.
   task automatic modelStep();
      bit anyDrop;
      anyDrop = 1'b0;
      for (int r = 0; r < ROWS; r++) begin
         for (int c = 0; c < COLS; c++) begin
            if (mPend[r][c]) begin
               if (eventIn[r][c] != 2'b00) anyDrop = 1'b1;
               if (gntIn[r][c]) begin
                  mPend[r][c]   = 1'b0;
                  mFreeAt[r][c] = edgeIdx + REFRAC;
               end
            end else if (edgeIdx <= mFreeAt[r][c]) begin
               if (eventIn[r][c] != 2'b00) anyDrop = 1'b1;
            end else if (enable_i && eventIn[r][c] != 2'b00) begin
               mPend[r][c] = 1'b1;
               mPol[r][c]  = eventIn[r][c][1] ? 2'b10 : 2'b01;
               if (eventIn[r][c] == 2'b11) anyDrop = 1'b1;
            end
         end
      end
      mDrop = anyDrop;
      if (anyDrop && mCnt < 65535) mCnt++;
      edgeIdx++;
   endtask

   function automatic logic [7:0] expReq();
      logic [ROWS-1:0][COLS-1:0][1:0] v;
      v = '0;
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            if (mPend[r][c]) v[r][c] = mPol[r][c];
      return v;
   endfunction

   function automatic logic expBusy();
      logic b;
      b = 1'b0;
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            if (mPend[r][c] || edgeIdx <= mFreeAt[r][c]) b = 1'b1;
      return b;
   endfunction

   task automatic tick(input string tag);
      @(posedge clk_i);
      modelStep();
      #1;
      check({tag, ".req"},  32'(reqOut),     32'(expReq()));
      check({tag, ".busy"}, 32'(busyOut),    32'(expBusy()));
      check({tag, ".drop"}, 32'(dropOut),    32'(mDrop));
      check({tag, ".cnt"},  32'(dropCntOut), 32'(mCnt));
   endtask

   task automatic applyStimulus(input logic en, input logic [7:0] ev, input logic [3:0] g);
      enable_i = en;
      eventIn  = ev;
      gntIn    = g;
   endtask

   task automatic checkOutput(input string tag);
      check({tag, ".req"},  32'(reqOut),     32'd0);
      check({tag, ".busy"}, 32'(busyOut),    32'd0);
      check({tag, ".drop"}, 32'(dropOut),    32'd0);
      check({tag, ".cnt"},  32'(dropCntOut), 32'd0);
   endtask

   task automatic doReset();
      reset_i = 1'b1;
      #1;
      modelReset();
      @(posedge clk_i);
      #1;
      reset_i = 1'b0;
   endtask

   initial begin
      reset_i = 1'b1;
      applyStimulus(1'b0, 8'h00, 4'h0);
      modelReset();
      repeat (2) @(posedge clk_i);
      #1;
      checkOutput("reset");
      reset_i = 1'b0;

      // Single event, held until grant, then refractory
      enable_i = 1'b1;
      eventIn[1][0] = 2'b01;
      tick("single.cap");
      eventIn = '0;
      check("single.req10", 32'(reqOut[1][0]), 32'd1);
      check("single.busy", 32'(busyOut), 32'd1);
      repeat (4) tick("single.hold");
      check("single.held", 32'(reqOut[1][0]), 32'd1);
      gntIn[1][0] = 1'b1;
      tick("single.gnt");
      gntIn = '0;
      check("single.cleared", 32'(reqOut[1][0]), 32'd0);
      check("single.refbusy", 32'(busyOut), 32'd1);

      // Event during refractory is dropped; after refractory a new one is accepted
      tick("refrac.1");
      eventIn[1][0] = 2'b01;
      tick("refrac.evt");
      eventIn = '0;
      check("refrac.noreq", 32'(reqOut[1][0]), 32'd0);
      check("refrac.drop", 32'(dropOut), 32'd1);
      check("refrac.cnt", 32'(dropCntOut), 32'd1);
      tick("refrac.2");
      check("refrac.dropgone", 32'(dropOut), 32'd0);
      tick("refrac.end");
      check("refrac.idle", 32'(busyOut), 32'd0);
      eventIn[1][0] = 2'b10;
      tick("refrac.new");
      eventIn = '0;
      check("refrac.newreq", 32'(reqOut[1][0]), 32'd2);
      gntIn[1][0] = 1'b1;
      tick("refrac.gnt2");
      gntIn = '0;
      repeat (4) tick("refrac.drain");

      // Two-polarity collision latches ON and counts a drop
      eventIn[0][1] = 2'b11;
      tick("coll.cap");
      eventIn = '0;
      check("coll.req", 32'(reqOut[0][1]), 32'd2);
      check("coll.cnt", 32'(dropCntOut), 32'd2);
      check("coll.drop", 32'(dropOut), 32'd1);
      gntIn[0][1] = 1'b1;
      tick("coll.gnt");
      gntIn = '0;
      repeat (4) tick("coll.drain");

      // All pixels at once, granted one per cycle
      eventIn[0][0] = 2'b01;
      eventIn[0][1] = 2'b10;
      eventIn[1][0] = 2'b10;
      eventIn[1][1] = 2'b01;
      tick("all.cap");
      eventIn = '0;
      check("all.req", 32'(reqOut), 32'h69);
      gntIn = 4'b0001;
      tick("all.g00");
      check("all.after00", 32'(reqOut), 32'h68);
      gntIn = 4'b0010;
      tick("all.g01");
      check("all.after01", 32'(reqOut), 32'h60);
      gntIn = 4'b0100;
      tick("all.g10");
      check("all.after10", 32'(reqOut), 32'h40);
      gntIn = 4'b1000;
      tick("all.g11");
      gntIn = '0;
      check("all.after11", 32'(reqOut), 32'h00);
      repeat (4) tick("all.drain");
      check("all.idle", 32'(busyOut), 32'd0);

      // Disabled capture: no request and no drop
      enable_i = 1'b0;
      eventIn[0][0] = 2'b01;
      eventIn[1][1] = 2'b11;
      tick("dis.evt");
      eventIn = '0;
      enable_i = 1'b1;
      check("dis.req", 32'(reqOut), 32'd0);
      check("dis.drop", 32'(dropOut), 32'd0);
      check("dis.cnt", 32'(dropCntOut), 32'd2);

      // Asynchronous reset during PEND, then immediate recapture
      eventIn[0][0] = 2'b10;
      tick("arst.cap");
      eventIn = '0;
      check("arst.pend", 32'(reqOut[0][0]), 32'd2);
      #2;
      reset_i = 1'b1;
      #1;
      modelReset();
      check("arst.req", 32'(reqOut), 32'd0);
      check("arst.busy", 32'(busyOut), 32'd0);
      check("arst.cnt", 32'(dropCntOut), 32'd0);
      @(posedge clk_i);
      #1;
      reset_i = 1'b0;
      eventIn[1][1] = 2'b01;
      tick("arst.recap");
      eventIn = '0;
      check("arst.newreq", 32'(reqOut[1][1]), 32'd1);
      gntIn[1][1] = 1'b1;
      tick("arst.gnt");
      gntIn = '0;

      // Random traffic against the model
      for (int i = 0; i < 400; i++) begin
         applyStimulus(1'($urandom_range(0, 7) != 0),
                       8'($urandom & $urandom & $urandom),
                       4'($urandom));
         tick("rand");
      end

      // Drop counter saturation
      applyStimulus(1'b1, 8'h00, 4'h0);
      doReset();
      eventIn[0][0] = 2'b01;
      tick("sat.cap");
      for (int i = 0; i < 65537; i++) begin
         tick("sat");
      end
      check("sat.max", 32'(dropCntOut), 32'hFFFF);
      tick("sat.hold");
      check("sat.still", 32'(dropCntOut), 32'hFFFF);
      check("sat.drop", 32'(dropOut), 32'd1);
      eventIn = '0;

      $display("[TB] %0d tests run, %0d failed", testCnt, failCnt);
      $finish;
   end

endmodule

// File: doc/pixel_req_gen.md
PIXEL_REQ_GEN -- requirements
Module: pixel_req_gen

Interface
REQ-001 The block SHALL have parameter Lvl0_ROWS, default 2, meaning the number of pixel rows in the group.
REQ-002 The block SHALL have parameter Lvl0_COLS, default 2, meaning the number of pixel columns in the group.
REQ-003 The block SHALL have parameter REFRAC_CYCLES, default 4, meaning the refractory hold in clocks after a grant, legal range 0..255.
REQ-004 The block SHALL take POLARITY (=2) from lib_arbiter_pkg, with bit1 = ON event and bit0 = OFF event.
REQ-005 The block SHALL have port clk_i, input, 1 bit: the single clock, rising edge.
REQ-006 The block SHALL have port reset_i, input, 1 bit: reset, asynchronous and active-high.
REQ-007 The block SHALL have port enable_i, input, 1 bit: capture enable for new events.
REQ-008 The block SHALL have port event_i, input, [Lvl0_ROWS][Lvl0_COLS][POLARITY]: per-pixel event strobes, 1-cycle.
REQ-009 The block SHALL have port gnt_i, input, [Lvl0_ROWS][Lvl0_COLS]: per-pixel grant from the level-0 arbiter.
REQ-010 The block SHALL have port req_o, output, [Lvl0_ROWS][Lvl0_COLS][POLARITY]: per-pixel registered request with polarity.
REQ-011 The block SHALL have port busy_o, output, 1 bit: high when any pixel is in the PEND or REFRAC state.
REQ-012 The block SHALL have port drop_o, output, 1 bit: registered pulse, high for one cycle after any event was dropped.
REQ-013 The block SHALL have port drop_cnt_o, output, 16 bits: saturating count of cycles in which at least one event was dropped.

Function
REQ-014 Each pixel SHALL run an independent FSM with states IDLE, PEND and REFRAC, plus an 8-bit refractory counter.
REQ-015 IDLE -> PEND: at a clock edge with enable_i=1 and a nonzero event_i for that pixel.
  - The polarity is latched into req_o, visible in the cycle after the event (latency 1).
REQ-016 If both polarity bits are set in one cycle, the pixel SHALL latch ON (2'b10) and flag a drop.
REQ-017 In PEND, req_o SHALL hold the latched polarity unchanged until gnt_i for that pixel is sampled high.
REQ-018 PEND with gnt_i=1 SHALL transition as follows, with req_o=0 in the following cycle in both cases:
  - REFRAC_CYCLES > 0: go to REFRAC and load the counter with REFRAC_CYCLES.
  - REFRAC_CYCLES = 0: go to IDLE.
REQ-019 In REFRAC, the counter SHALL decrement each cycle; when the counter equals 1, the next state SHALL be IDLE, so the pixel stays exactly REFRAC_CYCLES cycles in REFRAC.
REQ-020 An event arriving while a pixel is in PEND or REFRAC SHALL be discarded and flagged as a drop; it is not queued.
REQ-021 An event and a grant in the same cycle on a PEND pixel: the grant SHALL be honoured and the event dropped.
REQ-022 gnt_i on a pixel in IDLE or REFRAC SHALL be ignored.
REQ-023 enable_i=0 SHALL block IDLE->PEND captures; those events are ignored and are not counted as drops. PEND and REFRAC pixels continue normally, so requests are held across arbiter refresh.
REQ-024 drop_o SHALL be registered, going high the cycle after any pixel flags a drop.
REQ-025 drop_cnt_o SHALL increment by 1 per such cycle, regardless of the number of pixels dropping, and saturate at 16'hFFFF.
REQ-026 busy_o SHALL be registered and equal the OR over pixels of (state != IDLE), evaluated on next-state values.

Reset
REQ-027 On reset_i=1, asynchronously, the block SHALL force:
  - all pixel FSMs to IDLE and all counters to 0;
  - req_o = 0, busy_o = 0, drop_o = 0, drop_cnt_o = 0.
REQ-028 Reset asserted mid-PEND or mid-REFRAC SHALL abandon the event with no grant required; after release, the first edge accepts new events.

Verification
REQ-029 Single event: enable=1, event_i[1][0]=2'b01 in cycle 0 -> req_o[1][0]=2'b01 in cycle 1; it holds until gnt_i[1][0] is pulsed in cycle 5 -> req_o[1][0]=0 in cycle 6; busy_o falls 4 cycles later (REFRAC_CYCLES=4).
REQ-030 Refractory drop: a second event on [1][0] 2 cycles after the grant -> no request, drop_o pulse, drop_cnt_o=1; an event after REFRAC ends -> new request.
REQ-031 Collision: event_i=2'b11 on [0][1] -> req_o[0][1]=2'b10 and drop_cnt_o incremented by 1.
REQ-032 Simultaneous: events on all 4 pixels in one cycle -> all 4 req_o set the next cycle; grants served one per cycle -> each pixel clears independently.
REQ-033 Disable and reset: enable=0 with an event -> no request and no drop. A reset during PEND -> req_o=0 immediately, without waiting for a clock edge.
REQ-034 Saturation: force 65537 drop cycles -> drop_cnt_o holds at 16'hFFFF.
